// File: rtl/hazard_scoreboard.sv
// Purpose : scoreboarded hazard unit; tracks in-flight writers for NSTAGE post-decode stages,
//           derives Tuse/Tnew stalls, D/E/M forwarding selects, E bubble and an MD busy countdown.
// Latency : all outputs are combinational from scoreboard state and D-stage inputs; state updates each clk.
// Backpressure: a stall freezes PC and F/D (pc_en=d_en=0) and injects a bubble into E (flush_e=1).
// Ports   : clk/reset (sync, active-high), clear (invalidate entries), D-stage instruction fields in,
//           pc_en/d_en/flush_e, fwd_* selects (0=RF/pipeline, k=stage k result), md_busy, perf_* counters.
// Optional: define HAZARD_PERF_EN to enable the perf_stall/perf_md_stall cycle counters (else tied to 0).
module hazard_scoreboard #(
    parameter int NSTAGE   = 3,
    parameter int TW       = 3,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    localparam int FSW     = $clog2(NSTAGE + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           valid_d,
    input  logic [4:0]     rs_d,
    input  logic [4:0]     rt_d,
    input  logic [4:0]     dst_d,
    input  logic           wr_d,
    input  logic [TW-1:0]  tnew_d,
    input  logic [TW-1:0]  tuse_rs_d,
    input  logic [TW-1:0]  tuse_rt_d,
    input  logic           md_start_d,
    input  logic           md_div_d,
    input  logic           md_use_d,
    output logic           pc_en,
    output logic           d_en,
    output logic           flush_e,
    output logic [FSW-1:0] fwd_rs_d,
    output logic [FSW-1:0] fwd_rt_d,
    output logic [FSW-1:0] fwd_rs_e,
    output logic [FSW-1:0] fwd_rt_e,
    output logic           fwd_rt_m,
    output logic           md_busy,
    output logic [31:0]    perf_stall,
    output logic [31:0]    perf_md_stall
);

    localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW     = $clog2(MD_MAX + 1);

    // Scoreboard: index 1 = E, NSTAGE = W.
    logic [NSTAGE:1] vld_q;
    logic [NSTAGE:1] wr_q;
    logic [4:0]      dst_q  [NSTAGE:1];
    logic [TW-1:0]   tnew_q [NSTAGE:1];
    // E-only fields: sources for E-stage forwarding, MD start info for the countdown.
    logic [4:0]      rs1_q;
    logic [4:0]      rt1_q;
    logic            mds1_q;
    logic            mdd1_q;

    logic [CW-1:0]   md_cnt_q;
    logic [CW-1:0]   md_cnt_d;

    logic [NSTAGE:1] m_rs_d;   // stage s writes rs_d
    logic [NSTAGE:1] m_rt_d;   // stage s writes rt_d
    logic [NSTAGE:2] m_rs_e;   // stage s writes the E-stage rs
    logic [NSTAGE:2] m_rt_e;   // stage s writes the E-stage rt
    logic [NSTAGE:2] rdy;      // stage s result already produced
    logic            stall;
    logic            md_stall;
    logic            stall_any;

    always_comb begin
        m_rs_d = '0;
        m_rt_d = '0;
        m_rs_e = '0;
        m_rt_e = '0;
        rdy    = '0;
        for (int s = 1; s <= NSTAGE; s++) begin
            m_rs_d[s] = vld_q[s] && wr_q[s] && (dst_q[s] != 5'd0) && (dst_q[s] == rs_d);
            m_rt_d[s] = vld_q[s] && wr_q[s] && (dst_q[s] != 5'd0) && (dst_q[s] == rt_d);
        end
        for (int s = 2; s <= NSTAGE; s++) begin
            m_rs_e[s] = vld_q[s] && wr_q[s] && (dst_q[s] != 5'd0) && (dst_q[s] == rs1_q);
            m_rt_e[s] = vld_q[s] && wr_q[s] && (dst_q[s] != 5'd0) && (dst_q[s] == rt1_q);
            rdy[s]    = (tnew_q[s] == '0);
        end
    end

    always_comb begin
        stall = 1'b0;
        if (valid_d) begin
            for (int s = 1; s <= NSTAGE; s++) begin
                if ((m_rs_d[s] && (tuse_rs_d < tnew_q[s])) ||
                    (m_rt_d[s] && (tuse_rt_d < tnew_q[s]))) begin
                    stall = 1'b1;
                end
            end
        end
    end

    assign md_busy   = (md_cnt_q != '0);
    // An MD start still sitting in E has not loaded the countdown yet, so it blocks too.
    assign md_stall  = valid_d && md_use_d && (md_busy || (vld_q[1] && mds1_q));
    assign stall_any = stall || md_stall;
    assign pc_en     = ~stall_any;
    assign d_en      = ~stall_any;
    assign flush_e   = stall_any;

    // Scan oldest to youngest so the youngest ready writer is the last one assigned.
    always_comb begin
        fwd_rs_d = '0;
        fwd_rt_d = '0;
        fwd_rs_e = '0;
        fwd_rt_e = '0;
        // D readers skip W: the register file writes through in the same cycle.
        for (int k = NSTAGE - 1; k >= 2; k--) begin
            if (m_rs_d[k] && rdy[k]) fwd_rs_d = FSW'(k);
            if (m_rt_d[k] && rdy[k]) fwd_rt_d = FSW'(k);
        end
        for (int k = NSTAGE; k >= 2; k--) begin
            if (m_rs_e[k] && rdy[k]) fwd_rs_e = FSW'(k);
            if (m_rt_e[k] && rdy[k]) fwd_rt_e = FSW'(k);
        end
    end

    assign fwd_rt_m = vld_q[NSTAGE] && wr_q[NSTAGE] && (dst_q[NSTAGE] != 5'd0) &&
                      (dst_q[NSTAGE] == dst_q[2]) && rdy[NSTAGE] && vld_q[2];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            vld_q  <= '0;
            wr_q   <= '0;
            rs1_q  <= '0;
            rt1_q  <= '0;
            mds1_q <= 1'b0;
            mdd1_q <= 1'b0;
            for (int s = 1; s <= NSTAGE; s++) begin
                dst_q[s]  <= '0;
                tnew_q[s] <= '0;
            end
        end else begin
            for (int s = 2; s <= NSTAGE; s++) begin
                vld_q[s]  <= vld_q[s-1];
                wr_q[s]   <= wr_q[s-1];
                dst_q[s]  <= dst_q[s-1];
                tnew_q[s] <= (tnew_q[s-1] == '0) ? '0 : tnew_q[s-1] - TW'(1);
            end
            if (valid_d && !stall_any) begin
                vld_q[1]  <= 1'b1;
                wr_q[1]   <= wr_d;
                dst_q[1]  <= dst_d;
                tnew_q[1] <= tnew_d;
                rs1_q     <= rs_d;
                rt1_q     <= rt_d;
                mds1_q    <= md_start_d;
                mdd1_q    <= md_div_d;
            end else begin
                // Bubble: zeroed fields keep E-stage forwarding selects at 0.
                vld_q[1]  <= 1'b0;
                wr_q[1]   <= 1'b0;
                dst_q[1]  <= '0;
                tnew_q[1] <= '0;
                rs1_q     <= '0;
                rt1_q     <= '0;
                mds1_q    <= 1'b0;
                mdd1_q    <= 1'b0;
            end
        end
    end

    // Countdown starts when the MD op leaves E; a later start simply reloads it.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (vld_q[1] && mds1_q) begin
            md_cnt_d = mdd1_q ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_md_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q    <= '0;
            perf_md_stall_q <= '0;
        end else begin
            if (stall)    perf_stall_q    <= perf_stall_q + 32'd1;
            if (md_stall) perf_md_stall_q <= perf_md_stall_q + 32'd1;
        end
    end

    assign perf_stall    = perf_stall_q;
    assign perf_md_stall = perf_md_stall_q;
`else
    assign perf_stall    = '0;
    assign perf_md_stall = '0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed E/M/W hazard unit.
- Keeps an internal scoreboard of in-flight writers (dst, write-enable, Tnew) for a configurable number of post-decode stages, so stage Dst/T values no longer come in as ports.
- From that scoreboard it derives Tuse/Tnew stalls, D/E/M forwarding selects and the E-stage bubble.
- Adds an internal multiply/divide busy countdown, replacing the external busy input.

Parameters:
NSTAGE, 3, post-decode stages tracked; stage 1=E, 2=M, ..., NSTAGE=W (min 3)
TW, 3, width of Tuse/Tnew fields
MULT_LAT, 5, busy cycles for mult/multu/msub
DIV_LAT, 10, busy cycles for div/divu
FSW, $clog2(NSTAGE+1), forwarding-select width (derived localparam)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
clear  in  1  sync invalidate of all scoreboard entries (exception/redirect)
valid_d  in  1  D-stage instruction valid
rs_d, rt_d  in  5  D-stage source regs
dst_d  in  5  D-stage destination
wr_d  in  1  D instruction writes RF
tnew_d  in  TW  Tnew at E entry
tuse_rs_d, tuse_rt_d  in  TW  Tuse of rs/rt
md_start_d  in  1  D instruction starts mult/div
md_div_d  in  1  1=div latency, 0=mult latency
md_use_d  in  1  D instruction touches HI/LO or MD unit
pc_en  out  1  PC write enable
d_en  out  1  F/D register enable
flush_e  out  1  insert bubble into E
fwd_rs_d, fwd_rt_d  out  FSW  D-stage forward select
fwd_rs_e, fwd_rt_e  out  FSW  E-stage forward select
fwd_rt_m  out  1  M store data from W
md_busy  out  1  MD countdown nonzero

Behaviour:
- Entry per stage s (1..NSTAGE): valid, wr, dst, tnew; stage 1 also holds rs, rt.
- Every cycle, stages 2..NSTAGE shift from s-1 with tnew decremented, saturating at 0. The stage-NSTAGE entry retires.
- Stage 1 loads D fields when valid_d and no stall; otherwise it loads a bubble (valid=0).
- Writer match(s,r): valid_s & wr_s & dst_s!=0 & dst_s==r.
- Stall: any s with match(s,rs_d) & tuse_rs_d<tnew_s, or match(s,rt_d) & tuse_rt_d<tnew_s. Only evaluated when valid_d.
- MD stall: valid_d & md_use_d & (md_busy | stage-1 entry is an md_start).
- stall_any = stall | MD stall.
- pc_en = d_en = ~stall_any; flush_e = stall_any. All combinational.
- MD counter:
  - Loads MULT_LAT or DIV_LAT on the cycle an md_start instruction advances out of stage 1.
  - Otherwise decrements to 0.
  - md_busy = counter!=0.
  - A new start while busy reloads the counter.
- Forward select encoding: 0 = RF/pipeline value; k = stage k result. Youngest (lowest k) match with tnew_k==0 wins.
  - D consumers consider k in 2..NSTAGE-1; W is covered by RF write-through.
  - E consumers use the stage-1 rs/rt and consider k in 2..NSTAGE.
- fwd_rt_m = 1 when match(NSTAGE, dst of stage 2) & tnew_NSTAGE==0 & stage 2 valid.
- Reg 0 never stalls or forwards.
- clear: all entries are invalid next cycle. The MD counter is not affected.
- reset: all entries invalid, counter 0. Resulting outputs: pc_en=1, d_en=1, flush_e=0, all fwd=0, fwd_rt_m=0, md_busy=0.
- clear and reset have priority over shift.

Optional Feature:
HAZARD_PERF_EN:
- With the macro: add outputs perf_stall  out  32 and perf_md_stall  out  32.
  - Each counts cycles with the Tuse/Tnew stall and with the MD stall respectively.
  - Both are cleared by reset only and wrap at 2^32.
- Without the macro: the ports exist but are tied to 0 and no counter flops are inferred.

Test Plan:
- Load-use: lw $8 (tnew_d=2, wr) then add rs=$8, tuse=1 → 1 cycle pc_en=0, flush_e=1. Next cycle fwd_rs_e=NSTAGE (W).
- ALU chain: addu $9 (tnew_d=1) then subu rt=$9, tuse=1 → no stall, fwd_rt_e=2 (M).
- Branch: addu $4 (tnew_d=1), beq rs=$4, tuse_rs=0 → 1 stall cycle, then fwd_rs_d=2 while beq is in D.
- MD: div (md_div_d=1) then mflo (md_use_d=1) → mflo held 1+DIV_LAT cycles, md_busy high exactly DIV_LAT cycles, then released.
- $0 and clear: writer with dst=0 → never stall/forward. clear while lw is in E → next-cycle consumer of that reg sees no stall.
- Store forward: lw $6 in W, sw rt=$6 in M → fwd_rt_m=1. With HAZARD_PERF_EN, perf_stall increments once per load-use stall.
